// File: rtl/servo_motion_ctrl_if.sv
// Command port of the servo motion sequencer: valid/ready handshake carrying
// a channel index and a requested pulse width in microseconds.
interface servo_motion_ctrl_if #(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_ch;
  logic [15:0]   cmd_width_us;

  modport master (output cmd_valid, output cmd_ch, output cmd_width_us, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ch, input cmd_width_us, output cmd_ready);
endinterface

// File: rtl/servo_motion_ctrl.sv
// Multi-channel servo motion sequencer: clamps commanded targets and, once per
// servo frame, slews each channel's output width toward its target.
module servo_motion_ctrl #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned FRAME_US = 20_000,
  parameter int unsigned MIN_US   = 1_000,
  parameter int unsigned MAX_US   = 2_000,
  parameter int unsigned HOME_US  = 1_500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  servo_motion_ctrl_if.slave     cmd,
  input  logic [15:0]            step_us,
  output logic [NUM_CH*16-1:0]   width_us_flat,
  output logic [NUM_CH-1:0]      at_target,
  output logic                   busy,
  output logic                   frame_tick
);

  localparam int unsigned CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned WW          = 16;
  localparam int unsigned FRAME_TICKS = FRAME_US * (CLK_HZ / 1_000_000);
  localparam logic [31:0]   LAST_TICK = 32'(FRAME_TICKS - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
  localparam logic [WW-1:0] MIN_W     = 16'(MIN_US);
  localparam logic [WW-1:0] MAX_W     = 16'(MAX_US);
  localparam logic [WW-1:0] HOME_W    = 16'(HOME_US);

  // The sweep must finish before the next frame boundary.
  if (FRAME_TICKS <= NUM_CH + 1) begin : g_frame_too_short
    $error("servo_motion_ctrl: FRAME_TICKS must exceed NUM_CH+1");
  end
  if (MIN_US > HOME_US || HOME_US > MAX_US) begin : g_home_out_of_range
    $error("servo_motion_ctrl: HOME_US must lie within [MIN_US, MAX_US]");
  end

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_UPDATE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            tick_q;
  logic            ready_q, ready_d;
  logic            upd_en;
  logic            accept;

  logic [WW-1:0]   cur_q [NUM_CH];
  logic [WW-1:0]   tgt_q [NUM_CH];
  logic [NUM_CH-1:0] at_q, at_d;
  logic            busy_q, busy_d;

  logic [WW-1:0]   cmd_clamped;
  logic [WW-1:0]   cur_sel, tgt_sel, diff, cur_new;

  // Frame timer; the tick is registered one cycle ahead of the counter wrap.
  always_comb begin
    cnt_d = (cnt_q == LAST_TICK) ? '0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST_TICK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ready_q <= ready_d;
    end
  end

  // Sequencer: idle accepts commands, update visits one channel per cycle.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    upd_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_q) begin
          state_d = ST_UPDATE;
          ch_d    = '0;
        end
      end
      ST_UPDATE: begin
        upd_en = 1'b1;
        if (ch_q == LAST_CH) begin
          state_d = ST_IDLE;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ch_d    = '0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  assign accept = cmd.cmd_valid && ready_q;

  always_comb begin
    if (cmd.cmd_width_us < MIN_W) begin
      cmd_clamped = MIN_W;
    end else if (cmd.cmd_width_us > MAX_W) begin
      cmd_clamped = MAX_W;
    end else begin
      cmd_clamped = cmd.cmd_width_us;
    end
  end

  // Slew step for the channel being visited; a step never overshoots.
  always_comb begin
    cur_sel = cur_q[0];
    tgt_sel = tgt_q[0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CW'(i)) begin
        cur_sel = cur_q[i];
        tgt_sel = tgt_q[i];
      end
    end
    diff = (tgt_sel > cur_sel) ? (tgt_sel - cur_sel) : (cur_sel - tgt_sel);
    if (step_us == '0 || diff <= step_us) begin
      cur_new = tgt_sel;
    end else if (tgt_sel > cur_sel) begin
      cur_new = cur_sel + step_us;
    end else begin
      cur_new = cur_sel - step_us;
    end
  end

  always_comb begin
    at_d = at_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (upd_en && ch_q == CW'(i)) begin
        at_d[i] = (cur_new == tgt_sel);
      end
    end
    busy_d = |(~at_d);
  end

  // Out-of-range channel indices match no target and are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cur_q[i] <= HOME_W;
        tgt_q[i] <= HOME_W;
      end
      at_q   <= '1;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept && cmd.cmd_ch == CW'(i)) begin
          tgt_q[i] <= cmd_clamped;
        end
        if (upd_en && ch_q == CW'(i)) begin
          cur_q[i] <= cur_new;
        end
      end
      at_q   <= at_d;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign width_us_flat[g*16 +: 16] = cur_q[g];
  end

  assign at_target     = at_q;
  assign busy          = busy_q;
  assign frame_tick    = tick_q;
  assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Self-checking bench for servo_motion_ctrl: directed scenarios plus random
// command/step traffic against a frame-level reference model.
module tb_servo_motion_ctrl;

  localparam int unsigned NCH  = 4;
  localparam int unsigned NCH6 = 6;
  localparam int unsigned FT   = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] step_us, step6;
  logic [NCH*16-1:0]  flat;
  logic [NCH-1:0]     at_t;
  logic               busy, tick;
  logic [NCH6*16-1:0] flat6;
  logic [NCH6-1:0]    at6;
  logic               busy6, tick6;

  int checks   = 0;
  int failures = 0;
  int m_cur[NCH];
  int m_tgt[NCH];

  servo_motion_ctrl_if #(.NUM_CH(NCH))  cif ();
  servo_motion_ctrl_if #(.NUM_CH(NCH6)) cif6 ();

  servo_motion_ctrl #(
    .NUM_CH(NCH), .CLK_HZ(1_000_000), .FRAME_US(100),
    .MIN_US(1000), .MAX_US(2000), .HOME_US(1500)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cif), .step_us(step_us),
    .width_us_flat(flat), .at_target(at_t), .busy(busy), .frame_tick(tick)
  );

  servo_motion_ctrl #(
    .NUM_CH(NCH6), .CLK_HZ(1_000_000), .FRAME_US(100),
    .MIN_US(1000), .MAX_US(2000), .HOME_US(1500)
  ) dut6 (
    .clk(clk), .rst_n(rst_n), .cmd(cif6), .step_us(step6),
    .width_us_flat(flat6), .at_target(at6), .busy(busy6), .frame_tick(tick6)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: pure arithmetic on per-channel current/target widths.
  function automatic int clampw(input int w);
    if (w < 1000) return 1000;
    if (w > 2000) return 2000;
    return w;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cur[c] = 1500;
      m_tgt[c] = 1500;
    end
  endfunction

  function automatic void model_sweep(input int step);
    for (int c = 0; c < NCH; c++) begin
      int d;
      d = m_tgt[c] - m_cur[c];
      if (d < 0) d = -d;
      if (d != 0) begin
        if (step == 0 || d <= step) m_cur[c] = m_tgt[c];
        else if (m_tgt[c] > m_cur[c]) m_cur[c] = m_cur[c] + step;
        else m_cur[c] = m_cur[c] - step;
      end
    end
  endfunction

  function automatic logic [NCH*16-1:0] exp_flat();
    logic [NCH*16-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*16 +: 16] = 16'(m_cur[c]);
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_at();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = (m_cur[c] == m_tgt[c]);
    return r;
  endfunction

  task automatic wait_tick(input int sel);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3 * FT; n++) begin
      @(negedge clk);
      if ((sel == 0 && tick) || (sel != 0 && tick6)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_tick got=no_tick exp=tick_within_%0d", 3 * FT);
    end
  endtask

  // Drive one command and hold it until the handshake completes.
  task automatic send_cmd(input int sel, input int ch, input int w);
    bit ok;
    ok = 1'b0;
    if (sel == 0) begin
      cif.cmd_valid = 1'b1; cif.cmd_ch = 2'(ch); cif.cmd_width_us = 16'(w);
    end else begin
      cif6.cmd_valid = 1'b1; cif6.cmd_ch = 3'(ch); cif6.cmd_width_us = 16'(w);
    end
    for (int n = 0; n < 3 * FT; n++) begin
      if ((sel == 0 && cif.cmd_ready) || (sel != 0 && cif6.cmd_ready)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cif.cmd_valid  = 1'b0;
    cif6.cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL handshake got=ready_never_high exp=accept ch=%0d", ch);
    end
    if (sel == 0 && ch < int'(NCH)) m_tgt[ch] = clampw(w);
  endtask

  // Wait for a frame boundary, advance the model, land after the full sweep.
  task automatic run_frame();
    wait_tick(0);
    model_sweep(int'(step_us));
    repeat (NCH + 1) @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    step_us = '0; step6 = '0;
    cif.cmd_valid = 1'b0;  cif.cmd_ch = '0;  cif.cmd_width_us = '0;
    cif6.cmd_valid = 1'b0; cif6.cmd_ch = '0; cif6.cmd_width_us = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks += 5;
    if (flat !== {NCH{16'd1500}}) begin failures++; $display("FAIL rst_width got=%h exp=%h", flat, {NCH{16'd1500}}); end
    if (at_t !== 4'hf) begin failures++; $display("FAIL rst_at_target got=%b exp=1111", at_t); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (tick !== 1'b0) begin failures++; $display("FAIL rst_frame_tick got=%b exp=0", tick); end
    if (cif.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cif.cmd_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (n < 3 * FT) begin
        @(negedge clk);
        n++;
        if (tick) break;
      end
      checks++;
      if (n != FT) begin failures++; $display("FAIL tick_period%0d got=%0d exp=%0d", p, n, FT); end
    end
    repeat (NCH + 2) @(negedge clk);
    checks += 3;
    if (flat !== {NCH{16'd1500}}) begin failures++; $display("FAIL idle_width got=%h exp=%h", flat, {NCH{16'd1500}}); end
    if (at_t !== 4'hf) begin failures++; $display("FAIL idle_at_target got=%b exp=1111", at_t); end
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_slew();
    step_us = 16'd100;
    send_cmd(0, 1, 2000);
    for (int k = 0; k < 5; k++) begin
      run_frame();
      checks += 4;
      if (flat !== exp_flat()) begin failures++; $display("FAIL slew_model f%0d got=%h exp=%h", k, flat, exp_flat()); end
      if (flat[31:16] !== 16'(1600 + 100 * k)) begin failures++; $display("FAIL slew_ch1 f%0d got=%0d exp=%0d", k, flat[31:16], 1600 + 100 * k); end
      if (at_t[1] !== (k == 4)) begin failures++; $display("FAIL slew_at1 f%0d got=%b exp=%b", k, at_t[1], k == 4); end
      if (busy !== (k != 4)) begin failures++; $display("FAIL slew_busy f%0d got=%b exp=%b", k, busy, k != 4); end
    end
  endtask

  task automatic test_clamp();
    int e0[3] = '{1200, 1000, 1000};
    int e2[3] = '{1800, 2000, 2000};
    step_us = 16'd300;
    send_cmd(0, 0, 500);
    send_cmd(0, 2, 2500);
    for (int k = 0; k < 3; k++) begin
      run_frame();
      checks += 4;
      if (flat[15:0] !== 16'(e0[k])) begin failures++; $display("FAIL clamp_ch0 f%0d got=%0d exp=%0d", k, flat[15:0], e0[k]); end
      if (flat[47:32] !== 16'(e2[k])) begin failures++; $display("FAIL clamp_ch2 f%0d got=%0d exp=%0d", k, flat[47:32], e2[k]); end
      if (flat !== exp_flat()) begin failures++; $display("FAIL clamp_model f%0d got=%h exp=%h", k, flat, exp_flat()); end
      if (at_t !== exp_at()) begin failures++; $display("FAIL clamp_at f%0d got=%b exp=%b", k, at_t, exp_at()); end
    end
  endtask

  task automatic test_jump_invalid();
    step_us = 16'd0;
    send_cmd(0, 3, 1100);
    run_frame();
    checks += 2;
    if (flat[63:48] !== 16'd1100) begin failures++; $display("FAIL jump_ch3 got=%0d exp=1100", flat[63:48]); end
    if (flat !== exp_flat()) begin failures++; $display("FAIL jump_model got=%h exp=%h", flat, exp_flat()); end
    // Six-channel build: indices 6 and 7 are out of range.
    send_cmd(1, 7, 1200);
    send_cmd(1, 6, 1200);
    wait_tick(1);
    repeat (NCH6 + 1) @(negedge clk);
    checks += 3;
    if (flat6 !== {NCH6{16'd1500}}) begin failures++; $display("FAIL invalid_width got=%h exp=%h", flat6, {NCH6{16'd1500}}); end
    if (at6 !== 6'h3f) begin failures++; $display("FAIL invalid_at got=%b exp=111111", at6); end
    if (busy6 !== 1'b0) begin failures++; $display("FAIL invalid_busy got=%b exp=0", busy6); end
    send_cmd(1, 5, 1200);
    wait_tick(1);
    repeat (NCH6 + 1) @(negedge clk);
    checks++;
    if (flat6 !== {16'd1200, {(NCH6-1){16'd1500}}}) begin failures++; $display("FAIL ch5_width got=%h exp=%h", flat6, {16'd1200, {(NCH6-1){16'd1500}}}); end
  endtask

  task automatic test_backpressure();
    int pre[NCH];
    int post[NCH];
    int ex;
    step_us = 16'd50;
    send_cmd(0, 2, 1900);
    send_cmd(0, 3, 1200);
    wait_tick(0);
    // Command presented in the tick cycle is accepted and used this sweep.
    cif.cmd_valid = 1'b1; cif.cmd_ch = 2'd0; cif.cmd_width_us = 16'd1300;
    checks++;
    if (cif.cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_at_tick got=%b exp=1", cif.cmd_ready); end
    m_tgt[0] = 1300;
    pre = m_cur;
    model_sweep(int'(step_us));
    post = m_cur;
    @(negedge clk);
    cif.cmd_ch = 2'd1; cif.cmd_width_us = 16'd1900;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (cif.cmd_ready !== (k == 5)) begin failures++; $display("FAIL bp_ready T+%0d got=%b exp=%b", k, cif.cmd_ready, k == 5); end
      for (int i = 0; i < NCH; i++) begin
        ex = (k >= i + 2) ? post[i] : pre[i];
        checks++;
        if (flat[i*16 +: 16] !== 16'(ex)) begin failures++; $display("FAIL bp_sweep T+%0d ch%0d got=%0d exp=%0d", k, i, flat[i*16 +: 16], ex); end
      end
    end
    checks += 2;
    if (at_t !== exp_at()) begin failures++; $display("FAIL bp_at got=%b exp=%b", at_t, exp_at()); end
    if (busy !== (exp_at() != 4'hf)) begin failures++; $display("FAIL bp_busy got=%b exp=%b", busy, exp_at() != 4'hf); end
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    m_tgt[1] = 1900;
    for (int k = 0; k < 2; k++) begin
      run_frame();
      checks++;
      if (flat !== exp_flat()) begin failures++; $display("FAIL bp_after f%0d got=%h exp=%h", k, flat, exp_flat()); end
    end
  endtask

  task automatic test_random();
    int ncmd, ch, w;
    for (int it = 0; it < 25; it++) begin
      step_us = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 600));
      ncmd = $urandom_range(0, 2);
      for (int j = 0; j < ncmd; j++) begin
        ch = $urandom_range(0, NCH - 1);
        w  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(500, 2500);
        send_cmd(0, ch, w);
      end
      run_frame();
      checks += 3;
      if (flat !== exp_flat()) begin failures++; $display("FAIL rand_width it%0d got=%h exp=%h", it, flat, exp_flat()); end
      if (at_t !== exp_at()) begin failures++; $display("FAIL rand_at it%0d got=%b exp=%b", it, at_t, exp_at()); end
      if (busy !== (exp_at() != 4'hf)) begin failures++; $display("FAIL rand_busy it%0d got=%b exp=%b", it, busy, exp_at() != 4'hf); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    step_us = 16'd0;
    for (int c = 0; c < NCH; c++) send_cmd(0, c, 1000);
    run_frame();
    step_us = 16'd10;
    for (int c = 0; c < NCH; c++) send_cmd(0, c, 2000);
    wait_tick(0);
    repeat (3) @(negedge clk);
    checks++;
    if (flat[15:0] !== 16'd1010) begin failures++; $display("FAIL mid_ramp_ch0 got=%0d exp=1010", flat[15:0]); end
    #1 rst_n = 1'b0;
    #1;
    checks += 5;
    if (flat !== {NCH{16'd1500}}) begin failures++; $display("FAIL mid_rst_width got=%h exp=%h", flat, {NCH{16'd1500}}); end
    if (at_t !== 4'hf) begin failures++; $display("FAIL mid_rst_at got=%b exp=1111", at_t); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    if (tick !== 1'b0) begin failures++; $display("FAIL mid_rst_tick got=%b exp=0", tick); end
    if (cif.cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", cif.cmd_ready); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (n < 3 * FT) begin
      @(negedge clk);
      n++;
      if (tick) break;
    end
    checks++;
    if (n != FT) begin failures++; $display("FAIL mid_first_tick got=%0d exp=%0d", n, FT); end
    repeat (NCH + 2) @(negedge clk);
    run_frame();
    checks++;
    if (flat !== exp_flat()) begin failures++; $display("FAIL mid_after got=%h exp=%h", flat, exp_flat()); end
  endtask

  initial begin
    test_reset();
    test_slew();
    test_clamp();
    test_jump_invalid();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
